// File: rtl/clk_enable_gen_if.sv
// Control and output bundle for clk_enable_gen: pause/realign controls,
// the divisor write port, and the per-channel tick and square outputs.
interface clk_enable_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 27
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              run;
  logic              clr;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  modport master (
    output run, clr, div_wr, div_sel, div_val,
    input  tick, sq
  );

  modport slave (
    input  run, clr, div_wr, div_sel, div_val,
    output tick, sq
  );
endinterface

// File: rtl/clk_enable_gen.sv
// Multi-channel tick-enable generator: per-channel divide-by-D single-cycle
// ticks and 50% square outputs, with shadowed divisors, pause and realign.
module clk_enable_gen #(
  parameter int                      NUM_CH   = 4,
  parameter int                      CNT_W    = 27,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {27'd25_000_000, 27'd200_000,
                                                 27'd50_000_000, 27'd100_000_000}
) (
  input  logic             master_clk,
  input  logic             rst_n,
  clk_enable_gen_if.slave  bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [CNT_W-1:0]  active_d [NUM_CH];
  logic [CNT_W-1:0]  div_eff  [NUM_CH];
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic [NUM_CH-1:0] wrap;

  // NOTE: every signal gets its hold/default value before any branch, so no
  // path through this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = (bus.div_wr && (bus.div_sel == SEL_W'(i))) ? bus.div_val : shadow_q[i];
      div_eff[i]  = (active_q[i] == '0) ? CNT_W'(1) : active_q[i];
      wrap[i]     = (count_q[i] == div_eff[i] - CNT_W'(1));

      count_d[i]  = count_q[i];
      tick_d[i]   = 1'b0;
      sq_d[i]     = sq_q[i];
      active_d[i] = active_q[i];

      if (bus.clr) begin
        count_d[i]  = '0;
        sq_d[i]     = 1'b0;
        active_d[i] = shadow_d[i];
      end else if (!bus.run) begin
        count_d[i]  = count_q[i];
      end else if (wrap[i]) begin
        // A divisor written in this same cycle takes effect at this wrap.
        count_d[i]  = '0;
        tick_d[i]   = 1'b1;
        sq_d[i]     = ~sq_q[i];
        active_d[i] = shadow_d[i];
      end else begin
        count_d[i]  = count_q[i] + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]  <= '0;
        shadow_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
        active_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end
      tick_q <= '0;
      sq_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]  <= count_d[i];
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign bus.tick = tick_q;
  assign bus.sq   = sq_q;
endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen: a countdown reference model queues the
// expected {sq,tick} per edge; an independent monitor pops and compares.
module tb_clk_enable_gen;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd3, 8'd4};
  localparam int INIT_D [NUM_CH] = '{4, 3};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clk_enable_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clk_enable_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) dut (
    .master_clk (clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q [$];
  logic [3:0] mon_exp;

  // Reference model: cycles left until the next tick, pending divisor, square level.
  int m_left   [NUM_CH];
  int m_shadow [NUM_CH];
  bit m_sq     [NUM_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int at_least_one(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_shadow[ch] = INIT_D[ch];
      m_left[ch]   = at_least_one(INIT_D[ch]);
      m_sq[ch]     = 1'b0;
    end
  endtask

  task automatic model_edge(input bit run, input bit clr, input bit wr, input int sel,
                            input int val, output logic [3:0] e);
    logic [1:0] t;
    logic [1:0] s;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      int nsh;
      nsh   = (wr && sel == ch) ? val : m_shadow[ch];
      t[ch] = 1'b0;
      if (clr) begin
        m_left[ch] = at_least_one(nsh);
        m_sq[ch]   = 1'b0;
      end else if (run) begin
        m_left[ch]--;
        if (m_left[ch] == 0) begin
          t[ch]      = 1'b1;
          m_sq[ch]   = ~m_sq[ch];
          m_left[ch] = at_least_one(nsh);
        end
      end
      m_shadow[ch] = nsh;
      s[ch]        = m_sq[ch];
    end
    e = {s, t};
  endtask

  // Drive one cycle of inputs, queue the model's response to the coming edge.
  task automatic step(input bit run, input bit clr, input bit wr, input int sel, input int val);
    logic [3:0] e;
    bus.run     = run;
    bus.clr     = clr;
    bus.div_wr  = wr;
    bus.div_sel = 1'(sel);
    bus.div_val = val[CNT_W-1:0];
    model_edge(run, clr, wr, sel, val, e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic steps_to_tick(input int ch, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      step(1, 0, 0, 0, 0);
      if (bus.tick[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  // After reset or clr with divisors 4/3: edge k ticks ch0 when k%4==0, ch1 when k%3==0.
  task automatic check_from_origin(input string tag, input int n);
    logic [3:0] e;
    for (int k = 1; k <= n; k++) begin
      e[0] = (k % 4 == 0);
      e[1] = (k % 3 == 0);
      e[2] = ((k / 4) % 2 == 1);
      e[3] = ((k / 3) % 2 == 1);
      step(1, 0, 0, 0, 0);
      check(tag, {bus.sq, bus.tick}, e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      check("sb", {bus.sq, bus.tick}, mon_exp);
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [1:0] e2;
    rst_n       = 1'b0;
    bus.run     = 1'b0;
    bus.clr     = 1'b0;
    bus.div_wr  = 1'b0;
    bus.div_sel = '0;
    bus.div_val = '0;
    model_reset();
    #2;
    check("reset_out", {bus.sq, bus.tick}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running pattern out of reset.
    check_from_origin("t1_pattern", 12);

    // Pause with count0 at 2: outputs frozen, tick0 two running edges later.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0);
      check("t2_paused", {bus.sq, bus.tick}, 4'b0100);
    end
    steps_to_tick(0, 20, n);
    check("t2_resume_gap", n, 2);

    // Divisor write mid-period, then in the wrap cycle.
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 6);
    steps_to_tick(1, 20, n);
    check("t3_old_period", n, 1);
    steps_to_tick(1, 20, n);
    check("t3_new_period", n, 6);
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 2);
    check("t3_wrap_write_tick", bus.tick[1], 1);
    steps_to_tick(1, 20, n);
    check("t3_wrap_write_period", n, 2);

    // Divisor 0 behaves as 1 after clr.
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    check("t4_clr", {bus.sq[0], bus.tick[0]}, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      e2 = {k[0], 1'b1};
      step(1, 0, 0, 0, 0);
      check("t4_every_cycle", {bus.sq[0], bus.tick[0]}, e2);
    end

    // clr with same-cycle write, then clr exactly on ch0's wrap cycle.
    step(1, 1, 1, 0, 4);
    step(1, 0, 1, 1, 3);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("t5_clr_on_wrap", {bus.sq, bus.tick}, 4'b0000);
    check_from_origin("t5_realign", 6);

    // Async reset mid-count with non-default divisors active.
    step(1, 0, 1, 0, 7);
    step(1, 1, 1, 1, 5);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check("t6_async_reset", {bus.sq, bus.tick}, 4'b0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_from_origin("t6_after_reset", 12);

    // Randomized traffic against the scoreboard.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 5) == 0), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)));
    end

    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
